// File: rtl/pll_cfg_pkg.sv
// Shared types, register map and per-mode counter table for the PLL reconfiguration sequencer.
// Table words use the reconfig IP counter encoding:
//   M/N: [7:0] low count, [15:8] high count, [16] bypass, [17] odd division
//   C:   same low/high/bypass/odd fields plus [22:18] counter select
package pll_cfg_pkg;

    localparam int unsigned NUM_MODES = 2;
    localparam int unsigned TBL_LEN   = 3;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned IDX_W     = (TBL_LEN > 1) ? $clog2(TBL_LEN) : 1;

    localparam logic [ADDR_W-1:0] ADDR_MODE  = 6'h00;
    localparam logic [ADDR_W-1:0] ADDR_START = 6'h02;
    localparam logic [ADDR_W-1:0] ADDR_N     = 6'h03;
    localparam logic [ADDR_W-1:0] ADDR_M     = 6'h04;
    localparam logic [ADDR_W-1:0] ADDR_C     = 6'h05;

    // Mode 0: 50 MHz * 31 / 2 = 775 MHz VCO, C1 = 54 -> 14.351851 MHz
    localparam logic [DATA_W-1:0] MODE0_M = 32'h0002_100F; // 31: hi 16, lo 15, odd
    localparam logic [DATA_W-1:0] MODE0_N = 32'h0000_0101; // 2:  hi 1,  lo 1
    localparam logic [DATA_W-1:0] MODE0_C = 32'h0004_1B1B; // C1 = 54: hi 27, lo 27
    // Mode 1: 50 MHz * 12 / 1 = 600 MHz VCO, C1 = 24 -> 25 MHz
    localparam logic [DATA_W-1:0] MODE1_M = 32'h0000_0606; // 12: hi 6, lo 6
    localparam logic [DATA_W-1:0] MODE1_N = 32'h0001_0000; // 1: bypassed
    localparam logic [DATA_W-1:0] MODE1_C = 32'h0004_0C0C; // C1 = 24: hi 12, lo 12

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_MODE,
        ST_WR_TBL,
        ST_WR_START,
        ST_WAIT_START,
        ST_WAIT_LOCK
    } state_e;

    typedef enum logic {
        MODE_14M35 = 1'b0,
        MODE_25M   = 1'b1
    } mode_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mgmt_wr_t;

    // Table lookup: write order per mode is M, N, C1; out-of-range index yields zeros
    function automatic mgmt_wr_t tbl_entry(input mode_e mode, input logic [IDX_W-1:0] idx);
        mgmt_wr_t e;
        e = '0;
        case (idx)
            IDX_W'(0): begin
                e.addr = ADDR_M;
                e.data = (mode == MODE_25M) ? MODE1_M : MODE0_M;
            end
            IDX_W'(1): begin
                e.addr = ADDR_N;
                e.data = (mode == MODE_25M) ? MODE1_N : MODE0_N;
            end
            IDX_W'(2): begin
                e.addr = ADDR_C;
                e.data = (mode == MODE_25M) ? MODE1_C : MODE0_C;
            end
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/pll_cfg_rom.sv
// Combinational (mode, idx) -> {address, writedata} lookup over the package counter table.
// Ports:
//   mode    in  1       table mode index
//   idx     in  IDX_W   entry index within the mode
//   addr_c  out 6       management register address
//   data_c  out 32      counter word
module pll_cfg_rom
    import pll_cfg_pkg::*;
(
    input  logic              mode,
    input  logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] addr_c,
    output logic [DATA_W-1:0] data_c
);

    mgmt_wr_t entry_c;

    always_comb begin
        entry_c = tbl_entry(mode_e'(mode), idx);
    end

    assign addr_c = entry_c.addr;
    assign data_c = entry_c.data;

endmodule

// File: rtl/pll_reconfig_seq.sv
// Sequencer driving the PLL reconfiguration IP management port: on request it writes
// waitrequest mode, the selected mode's M/N/C1 words and START, waits for the IP to finish,
// then waits for a stable synchronized lock (or times out).
// Ports:
//   refclk           in   1   sole clock, rising edge
//   rst              in   1   synchronous active-high reset
//   req              in   1   single-cycle reconfiguration request
//   mode_sel         in   1   mode index, sampled on accepted req
//   busy             out  1   high from accept until done
//   done             out  1   one-cycle end-of-sequence pulse
//   error            out  1   sticky lock timeout, cleared by next accepted req
//   cur_mode         out  1   mode of last successful reconfiguration
//   pll_locked       in   1   raw PLL lock, asynchronous
//   mgmt_reset       out  1   reconfig IP reset (follows rst)
//   mgmt_address     out  6   Avalon address
//   mgmt_write       out  1   Avalon write strobe
//   mgmt_writedata   out  32  Avalon write data
//   mgmt_waitrequest in   1   Avalon waitrequest
module pll_reconfig_seq
    import pll_cfg_pkg::*;
#(
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        req,
    input  logic        mode_sel,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cur_mode,
    input  logic        pll_locked,
    output logic        mgmt_reset,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest
);

    localparam int unsigned STB_W = $clog2(LOCK_STABLE + 1);
    localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                mode_q, mode_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                cur_mode_q, cur_mode_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                lk_meta_q, lk_meta_d;
    logic                lk_sync_q, lk_sync_d;
    logic [STB_W-1:0]    stable_q, stable_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;

    logic                wr_acc_c;
    logic                mode_ok_c;
    logic                last_idx_c;
    logic                stable_hit_c;
    logic                tmo_hit_c;
    logic [IDX_W-1:0]    rom_idx_c;
    logic [ADDR_W-1:0]   rom_addr_c;
    logic [DATA_W-1:0]   rom_data_c;

    // Table index to fetch: first entry while writing MODE, otherwise the entry after the current one
    assign rom_idx_c = (state_q == ST_WR_MODE) ? '0 : idx_q + IDX_W'(1);

    pll_cfg_rom u_rom (
        .mode   (mode_q),
        .idx    (rom_idx_c),
        .addr_c (rom_addr_c),
        .data_c (rom_data_c)
    );

    assign wr_acc_c     = wr_q & ~mgmt_waitrequest;
    assign mode_ok_c    = (32'(mode_sel) < NUM_MODES);
    assign last_idx_c   = (idx_q == IDX_W'(TBL_LEN - 1));
    assign stable_hit_c = lk_sync_q && ((stable_q + STB_W'(1)) == STB_W'(LOCK_STABLE));
    assign tmo_hit_c    = ((tmo_q + TMO_W'(1)) == TMO_W'(LOCK_TIMEOUT));

    // Next-state, Avalon driver and lock-qualification logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mode_d     = mode_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        cur_mode_d = cur_mode_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        lk_meta_d  = pll_locked;
        lk_sync_d  = lk_meta_q;
        stable_d   = stable_q;
        tmo_d      = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_WR_MODE;
                    mode_d  = mode_ok_c ? mode_sel : 1'b0;
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                    idx_d   = '0;
                    wr_d    = 1'b1;
                    addr_d  = ADDR_MODE;
                    data_d  = '0;
                end
            end
            ST_WR_MODE: begin
                if (wr_acc_c) begin
                    state_d = ST_WR_TBL;
                    idx_d   = '0;
                    addr_d  = rom_addr_c;
                    data_d  = rom_data_c;
                end
            end
            ST_WR_TBL: begin
                if (wr_acc_c) begin
                    if (last_idx_c) begin
                        state_d = ST_WR_START;
                        addr_d  = ADDR_START;
                        data_d  = '0;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        addr_d = rom_addr_c;
                        data_d = rom_data_c;
                    end
                end
            end
            ST_WR_START: begin
                if (wr_acc_c) begin
                    state_d = ST_WAIT_START;
                    wr_d    = 1'b0;
                end
            end
            ST_WAIT_START: begin
                // IP holds waitrequest while it shifts the new counter settings
                if (!mgmt_waitrequest) begin
                    state_d  = ST_WAIT_LOCK;
                    stable_d = '0;
                    tmo_d    = '0;
                end
            end
            ST_WAIT_LOCK: begin
                stable_d = lk_sync_q ? stable_q + STB_W'(1) : '0;
                tmo_d    = tmo_q + TMO_W'(1);
                // Success takes priority when both terminal counts land together
                if (stable_hit_c) begin
                    state_d    = ST_IDLE;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    cur_mode_d = mode_q;
                end else if (tmo_hit_c) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cur_mode_q <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            lk_meta_q  <= 1'b0;
            lk_sync_q  <= 1'b0;
            stable_q   <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            cur_mode_q <= cur_mode_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            lk_meta_q  <= lk_meta_d;
            lk_sync_q  <= lk_sync_d;
            stable_q   <= stable_d;
            tmo_q      <= tmo_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign cur_mode       = cur_mode_q;
    assign mgmt_reset     = rst;
    assign mgmt_address   = addr_q;
    assign mgmt_write     = wr_q;
    assign mgmt_writedata = data_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: write ordering, waitrequest stalls, lock qualification,
// timeout, request filtering and reset behaviour.
module tb_pll_reconfig_seq;

    logic        refclk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        mode_sel = 1'b0;
    logic        busy, done, error, cur_mode;
    logic        pll_locked = 1'b0;
    logic        mgmt_reset;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    logic [5:0]  acc_addr [$];
    logic [31:0] acc_data [$];

    logic [5:0] exp_addr [5] = '{6'h00, 6'h04, 6'h03, 6'h05, 6'h02};

    pll_reconfig_seq dut (
        .refclk           (refclk),
        .rst              (rst),
        .req              (req),
        .mode_sel         (mode_sel),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .cur_mode         (cur_mode),
        .pll_locked       (pll_locked),
        .mgmt_reset       (mgmt_reset),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_waitrequest (mgmt_waitrequest)
    );

    always #5 refclk = ~refclk;

    // Record every write that the next rising edge will accept
    always begin
        @(negedge refclk);
        #1;
        if (mgmt_write && !mgmt_waitrequest) begin
            acc_addr.push_back(mgmt_address);
            acc_data.push_back(mgmt_writedata);
        end
    end

    // Expected write data: k = 0 MODE, 1 M, 2 N, 3 C1, 4 START
    function automatic logic [31:0] exp_data(input int m, input int k);
        case (k)
            1:       return (m == 1) ? 32'h0000_0606 : 32'h0002_100F;
            2:       return (m == 1) ? 32'h0001_0000 : 32'h0000_0101;
            3:       return (m == 1) ? 32'h0004_0C0C : 32'h0004_1B1B;
            default: return 32'h0;
        endcase
    endfunction

    task automatic pulse_req(input logic m);
        @(negedge refclk);
        req = 1'b1;
        mode_sel = m;
        @(negedge refclk);
        req = 1'b0;
        mode_sel = 1'b0;
        #1;
    endtask

    task automatic wait_start_acc(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge refclk);
            #1;
            if (mgmt_write && !mgmt_waitrequest && mgmt_address == 6'h02) ok = 1'b1;
        end
    endtask

    // Counts rising edges until done is seen high
    task automatic wait_done(input int limit, output int n, output bit got);
        n = 0;
        got = 1'b0;
        while (!got && n < limit) begin
            @(posedge refclk);
            n++;
            @(negedge refclk);
            #1;
            if (done) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge refclk);
        #1;
        n_checks++; if (mgmt_reset !== 1'b1) begin n_fail++; $display("FAIL reset_mgmt_reset got %b exp 1", mgmt_reset); end
        n_checks++; if ({busy, done, error, cur_mode, mgmt_write} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 00000", {busy, done, error, cur_mode, mgmt_write}); end
        n_checks++; if ({mgmt_address, mgmt_writedata} !== 38'h0) begin n_fail++; $display("FAIL reset_bus got %h/%h exp 0/0", mgmt_address, mgmt_writedata); end
        @(negedge refclk);
        rst = 1'b0;
        @(negedge refclk);
        #1;
        n_checks++; if (mgmt_reset !== 1'b0) begin n_fail++; $display("FAIL reset_release got %b exp 0", mgmt_reset); end
        acc_addr.delete(); acc_data.delete();
    endtask

    task automatic test_timeout();
        bit ok, got;
        int n;
        acc_addr.delete(); acc_data.delete();
        pll_locked = 1'b0;
        pulse_req(1'b1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_busy got %b exp 1", busy); end
        wait_start_acc(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo_start_write got none exp addr 02"); end
        wait_done(70000, n, got);
        n_checks++; if (!got || n != 65537) begin n_fail++; $display("FAIL tmo_latency got %0d (seen %b) exp 65537", n, got); end
        n_checks++; if ({error, busy, cur_mode} !== 3'b100) begin n_fail++; $display("FAIL tmo_status got e%b b%b m%b exp e1 b0 m0", error, busy, cur_mode); end
        n_checks++; if (acc_addr.size() != 5) begin n_fail++; $display("FAIL tmo_accepts got %0d exp 5", acc_addr.size()); end
        @(negedge refclk);
        #1;
        n_checks++; if ({done, error} !== 2'b01) begin n_fail++; $display("FAIL tmo_pulse got d%b e%b exp d0 e1", done, error); end
    endtask

    task automatic test_basic();
        bit ok, got;
        int n;
        pll_locked = 1'b1;
        repeat (5) @(negedge refclk);
        acc_addr.delete(); acc_data.delete();
        pll_locked = 1'b0;
        pulse_req(1'b1);
        n_checks++; if ({busy, error} !== 2'b10) begin n_fail++; $display("FAIL basic_accept got b%b e%b exp b1 e0", busy, error); end
        wait_start_acc(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_start_write got none exp addr 02"); end
        repeat (10) @(negedge refclk);
        pll_locked = 1'b1;
        wait_done(400, n, got);
        n_checks++; if (!got || n != 258) begin n_fail++; $display("FAIL basic_lock_latency got %0d (seen %b) exp 258", n, got); end
        n_checks++; if ({busy, error, cur_mode} !== 3'b001) begin n_fail++; $display("FAIL basic_status got b%b e%b m%b exp b0 e0 m1", busy, error, cur_mode); end
        n_checks++; if (acc_addr.size() != 5) begin n_fail++; $display("FAIL basic_accepts got %0d exp 5", acc_addr.size()); end
        for (int k = 0; k < 5 && k < acc_addr.size(); k++) begin
            n_checks++;
            if (acc_addr[k] !== exp_addr[k] || acc_data[k] !== exp_data(1, k)) begin
                n_fail++;
                $display("FAIL basic_write%0d got %h/%h exp %h/%h", k, acc_addr[k], acc_data[k], exp_addr[k], exp_data(1, k));
            end
        end
        @(negedge refclk);
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got %b exp 0", done); end
    endtask

    task automatic test_waitreq();
        bit got;
        int holds;
        logic [5:0] h_addr;
        logic [31:0] h_data;
        pll_locked = 1'b1;
        acc_addr.delete(); acc_data.delete();
        pulse_req(1'b0);
        holds = 0;
        got = 1'b0;
        h_addr = '0;
        h_data = '0;
        for (int c = 0; c < 600 && !got; c++) begin
            req = (c == 3);
            mode_sel = (c == 3);
            if (mgmt_write && mgmt_address == 6'h03 && holds < 5) begin
                mgmt_waitrequest = 1'b1;
                if (holds == 0) begin
                    h_addr = mgmt_address;
                    h_data = mgmt_writedata;
                end else begin
                    n_checks++;
                    if (mgmt_write !== 1'b1 || mgmt_address !== h_addr || mgmt_writedata !== h_data) begin
                        n_fail++;
                        $display("FAIL wait_hold%0d got w%b %h/%h exp w1 %h/%h", holds, mgmt_write, mgmt_address, mgmt_writedata, h_addr, h_data);
                    end
                end
                holds++;
            end else begin
                mgmt_waitrequest = 1'b0;
            end
            @(negedge refclk);
            if (done) got = 1'b1;
        end
        req = 1'b0;
        mode_sel = 1'b0;
        mgmt_waitrequest = 1'b0;
        #1;
        n_checks++; if (!got || holds != 5) begin n_fail++; $display("FAIL wait_done_holds got done %b holds %0d exp done 1 holds 5", got, holds); end
        n_checks++; if (acc_addr.size() != 5) begin n_fail++; $display("FAIL wait_accepts got %0d exp 5", acc_addr.size()); end
        for (int k = 0; k < 5 && k < acc_addr.size(); k++) begin
            n_checks++;
            if (acc_addr[k] !== exp_addr[k] || acc_data[k] !== exp_data(0, k)) begin
                n_fail++;
                $display("FAIL wait_write%0d got %h/%h exp %h/%h", k, acc_addr[k], acc_data[k], exp_addr[k], exp_data(0, k));
            end
        end
        n_checks++; if ({cur_mode, error} !== 2'b00) begin n_fail++; $display("FAIL wait_status got m%b e%b exp m0 e0", cur_mode, error); end
    endtask

    task automatic test_glitch();
        bit ok, got;
        int n, early;
        pll_locked = 1'b0;
        repeat (4) @(negedge refclk);
        pulse_req(1'b1);
        wait_start_acc(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL glitch_start_write got none exp addr 02"); end
        repeat (5) @(negedge refclk);
        pll_locked = 1'b1;
        early = 0;
        for (int i = 0; i < 202; i++) begin
            @(posedge refclk);
            @(negedge refclk);
            if (done) early++;
        end
        pll_locked = 1'b0;
        @(negedge refclk);
        pll_locked = 1'b1;
        n_checks++; if (early != 0) begin n_fail++; $display("FAIL glitch_early_done got %0d exp 0", early); end
        wait_done(400, n, got);
        n_checks++; if (!got || n != 258) begin n_fail++; $display("FAIL glitch_restart got %0d (seen %b) exp 258", n, got); end
        n_checks++; if ({cur_mode, error} !== 2'b10) begin n_fail++; $display("FAIL glitch_status got m%b e%b exp m1 e0", cur_mode, error); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        pll_locked = 1'b0;
        pulse_req(1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (mgmt_write && mgmt_address == 6'h04) seen = 1'b1;
            else @(negedge refclk);
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rstmid_tbl_write got none exp addr 04"); end
        rst = 1'b1;
        @(posedge refclk);
        #1;
        n_checks++; if ({busy, mgmt_write, done, error, cur_mode} !== 5'b0) begin n_fail++; $display("FAIL rstmid_flags got %b exp 00000", {busy, mgmt_write, done, error, cur_mode}); end
        n_checks++; if ({mgmt_address, mgmt_writedata} !== 38'h0 || mgmt_reset !== 1'b1) begin n_fail++; $display("FAIL rstmid_bus got %h/%h r%b exp 0/0 r1", mgmt_address, mgmt_writedata, mgmt_reset); end
        @(negedge refclk);
        rst = 1'b0;
        acc_addr.delete(); acc_data.delete();
        repeat (5) @(negedge refclk);
        #1;
        n_checks++; if (busy !== 1'b0 || acc_addr.size() != 0) begin n_fail++; $display("FAIL rstmid_idle got b%b writes %0d exp b0 writes 0", busy, acc_addr.size()); end
    endtask

    task automatic test_req_rst();
        acc_addr.delete(); acc_data.delete();
        @(negedge refclk);
        rst = 1'b1;
        req = 1'b1;
        mode_sel = 1'b1;
        @(negedge refclk);
        rst = 1'b0;
        req = 1'b0;
        mode_sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (busy !== 1'b0 || mgmt_write !== 1'b0) begin n_fail++; $display("FAIL reqrst_cycle%0d got b%b w%b exp b0 w0", i, busy, mgmt_write); end
            @(negedge refclk);
        end
        #1;
        n_checks++; if (acc_addr.size() != 0) begin n_fail++; $display("FAIL reqrst_writes got %0d exp 0", acc_addr.size()); end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_basic();
        test_waitreq();
        test_glitch();
        test_reset_mid();
        test_req_rst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
